// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Imported by the interface, the step datapath and the FSM top.
package muldiv_unit_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the mul/div unit.
// The master issues operands; the slave returns HI/LO and stall.
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, flush_i,
        input  busy_o, stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, flush_i,
        output busy_o, stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// One iteration: shift-add multiply or restoring divide step.
// Accumulator is {upper W+1 bits, lower W bits}.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  opnd_i,
    input  logic              div_i,
    output logic [2*WIDTH:0]  acc_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
        // shifted partial remainder minus divisor, W+1 bits wide
        diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
        if (div_i) begin
            if (diff[WIDTH])
                acc_o = {acc_i[2*WIDTH-1:0], 1'b0};
            else
                acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
        end else begin
            if (acc_i[0])
                acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
            else
                acc_o = {1'b0, acc_i[2*WIDTH:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per cycle.
// Works on magnitudes and fixes signs in a final cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [1:0]       op_q, op_d;
    logic             neg1_q, neg1_d;
    logic             neg2_q, neg2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sgn, n1, n2;
    logic [WIDTH-1:0] a1, a2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (op_q[1]),
        .acc_o  (acc_step)
    );

    always_comb begin
        sgn = ~bus.op_i[0];
        n1  = sgn & bus.data1_i[WIDTH-1];
        n2  = sgn & bus.data2_i[WIDTH-1];
        a1  = n1 ? -bus.data1_i : bus.data1_i;
        a2  = n2 ? -bus.data2_i : bus.data2_i;

        prod = acc_q[2*WIDTH-1:0];
        if (~op_q[0] & (neg1_q ^ neg2_q))
            prod = -prod;
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (~op_q[0] & (neg1_q ^ neg2_q))
            quot = -quot;
        if (~op_q[0] & neg1_q)
            rem = -rem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        orig_d  = orig_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        neg1_d  = neg1_q;
        neg2_d  = neg2_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = bus.op_i;
                    neg1_d  = n1;
                    neg2_d  = n2;
                    orig_d  = bus.data1_i;
                    // multiply iterates over the multiplier, divide over the dividend
                    opnd_d  = bus.op_i[1] ? a2 : a1;
                    acc_d   = {{(WIDTH+1){1'b0}}, bus.op_i[1] ? a1 : a2};
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (opnd_q == '0) begin
                    hi_d = orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            orig_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MULT;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            orig_q  <= orig_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            neg1_q  <= neg1_d;
            neg2_q  <= neg2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.stall_o = busy_q | (bus.start_i & ~bus.flush_i);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Expected HI/LO values are hand-computed constants.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    int   lat;
    int   bcnt;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        issue(op, a, b);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat  = 1;
        bcnt = bus.busy_o ? 1 : 0;
        while (!bus.done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy_o) bcnt++;
        end
        chk("done_seen", {63'd0, bus.done_o}, 64'd1);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = OP_MULT;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("rst_busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        chk("stall_start", {63'd0, bus.stall_o}, 64'd1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat  = 1;
        bcnt = bus.busy_o ? 1 : 0;
        while (!bus.done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy_o) bcnt++;
        end
        chk("multu_lat", 64'(lat), 64'd34);
        chk("multu_busy", 64'(bcnt), 64'd33);
        chk("multu", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFE_00000001);

        // back-to-back: start lands in the done cycle
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
        chk("b2b_lat", 64'(lat), 64'd34);
        chk("mult_neg", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFEB);
        @(posedge clk);
        #1;
        chk("done_pulse", {63'd0, bus.done_o}, 64'd0);

        run_op(OP_MULT, 32'h80000000, 32'h80000000);
        chk("mult_min", {bus.hi_o, bus.lo_o}, 64'h40000000_00000000);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_neg", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIVU, 32'd100, 32'd7);
        chk("divu", {bus.hi_o, bus.lo_o}, 64'h00000002_0000000E);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf", {bus.hi_o, bus.lo_o}, 64'h00000000_80000000);
        run_op(OP_DIVU, 32'd5, 32'd0);
        chk("divu_zero", {bus.hi_o, bus.lo_o}, 64'h00000005_FFFFFFFF);
        run_op(OP_DIV, 32'hFFFFFFF8, 32'd0);
        chk("div_zero", {bus.hi_o, bus.lo_o}, 64'hFFFFFFF8_FFFFFFFF);
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
        chk("div_pos_neg", {bus.hi_o, bus.lo_o}, 64'h00000001_FFFFFFFD);

        // flush mid-run: HI/LO keep the previous result
        issue(OP_MULTU, 32'd9, 32'd9);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("flush_done", {63'd0, bus.done_o}, 64'd0);
        chk("flush_hilo", {bus.hi_o, bus.lo_o}, 64'h00000001_FFFFFFFD);
        issue(OP_MULTU, 32'd3, 32'd3);
        #1;
        chk("flush_stall", {63'd0, bus.stall_o}, 64'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_start", {63'd0, bus.busy_o}, 64'd0);
        lat = 0;
        while (!bus.done_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("flush_nodone", {63'd0, bus.done_o}, 64'd0);
        run_op(OP_MULTU, 32'd6, 32'd7);
        chk("post_flush", {bus.hi_o, bus.lo_o}, 64'd42);

        // start while busy is ignored
        issue(OP_MULTU, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        issue(OP_DIVU, 32'd77, 32'd11);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        while (!bus.done_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_start", {bus.hi_o, bus.lo_o}, 64'd15);
        @(posedge clk);
        #1;
        chk("busy_idle", {62'd0, bus.busy_o, bus.done_o}, 64'd0);

        // reset mid-run
        issue(OP_MULTU, 32'd2, 32'd2);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        chk("rst_mid_flags", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
